// File: rtl/async_fifo_rd_stream.sv
// Read-side stream adapter: pops the async FIFO and re-presents words as a FWFT valid/ready stream.
// Latency: 2 r_clk from r_empty falling to m_valid (1 cycle RAM read + 1 cycle buffer write).
// Backpressure: credit-based, so a pop is only issued when a buffer slot is guaranteed; m_ready low stalls r_req.
//
// Ports:
//   r_clk, r_rst       read-domain clock, asynchronous active-low reset
//   r_empty / r_req    FIFO empty flag in, combinational pop request out
//   r_data             RAM read data, valid the cycle after an accepted pop
//   m_valid / m_ready  output stream handshake, m_data output word
//   buf_level          words currently held in the 2-entry output buffer
//   pop_count          words delivered downstream when RD_STREAM_STATS_EN is defined, else 0
module async_fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  r_empty,
    output logic                  r_req,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            buf_level,
    output logic [15:0]           pop_count
);

    logic [DATA_WIDTH-1:0] mem [0:1];
    logic                  rp;
    logic                  wp;
    logic [1:0]            cnt;
    logic                  inflight;   // r_data carries a popped word this cycle
    logic                  pop;
    logic                  out;
    logic [2:0]            cnt_next;

    assign m_valid   = (cnt != 2'd0);
    assign m_data    = mem[rp];
    assign buf_level = cnt;
    assign out       = m_valid && m_ready;

    // Occupancy after this cycle, counting the word already on r_data.
    // A new pop is only safe if that leaves a free slot for its data next cycle.
    assign cnt_next = {1'b0, cnt} + {2'b00, inflight} - {2'b00, out};
    assign r_req    = !r_empty && (cnt_next < 3'd2);
    assign pop      = r_req && !r_empty;

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            cnt      <= 2'd0;
            rp       <= 1'b0;
            wp       <= 1'b0;
            inflight <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            inflight <= pop;
            cnt      <= cnt_next[1:0];
            if (inflight) begin
                mem[wp] <= r_data;
                wp      <= ~wp;
            end
            if (out) begin
                rp <= ~rp;
            end
        end
    end

`ifdef RD_STREAM_STATS_EN
    logic [15:0] pop_cnt_q;

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            pop_cnt_q <= 16'd0;
        end else if (out) begin
            pop_cnt_q <= pop_cnt_q + 16'd1;
        end
    end

    assign pop_count = pop_cnt_q;
`else
    assign pop_count = 16'd0;
`endif

endmodule
